instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Front end of the CPU core: fetches 32-bit instruction words from program memory over a req/ack handshake and drives instr0 and current_state into the datapath.
- Owns the program counter and the core state machine, and detects the halt condition.
- The datapath acts on instr0 only while current_state equals STATE_EXEC, for exactly one cycle per instruction.

Parameters:
- ADDR_W, 10, program counter and memory address width in words.
- TIMEOUT, 255, maximum wait cycles for mem_ack before a fetch error; range 1..2^16-1.
- HALT_OP, 8'hFF, opcode in instr0[31:24] that stops execution.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level; when high in IDLE, begins fetching at address 0.
- step  in  1  single-cycle pulse; used only with SINGLE_STEP_EN.
- mem_req  out  1  fetch request, held until acknowledged.
- mem_addr  out  ADDR_W  word address of the fetch; equals pc.
- mem_ack  in  1  one-cycle pulse; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  instruction word.
- instr0  out  32  current instruction, registered.
- current_state  out  4  core state, registered.
- pc  out  ADDR_W  program counter.
- halted  out  1  high in HALT.
- fetch_err  out  1  sticky timeout flag.

Behaviour:
- State encodings (def.v): STATE_IDLE=4'd0, STATE_FETCH=4'd1, STATE_EXEC=4'd2, STATE_HALT=4'd3, STATE_STEP=4'd4.
- Reset (async assert, synchronous deassert at the next clk edge): current_state=IDLE, pc=0, instr0=0, mem_req=0, halted=0, fetch_err=0, wait counter=0.
- IDLE:
  - mem_req=0.
  - start=1 -> FETCH, pc=0.
- FETCH:
  - mem_req=1, mem_addr=pc.
  - Wait counter increments each cycle without ack.
  - mem_ack=1 -> instr0<=mem_rdata, mem_req<=0, counter<=0, -> EXEC. mem_ack may arrive in the first FETCH cycle, giving a minimum fetch of 1 cycle.
  - Counter reaches TIMEOUT with no ack -> fetch_err<=1, mem_req<=0, -> HALT. An ack in that same cycle takes priority and the fetch completes normally.
  - mem_ack outside FETCH is ignored.
- EXEC (exactly 1 cycle):
  - instr0 stable during EXEC.
  - instr0[31:24]==HALT_OP -> HALT; pc unchanged, pointing at the halt word.
  - Otherwise pc<=pc+1, wrapping modulo 2^ADDR_W (max -> 0), and -> FETCH (or STEP, see Optional Feature).
- HALT:
  - halted=1, mem_req=0.
  - start is ignored; only reset leaves HALT.
  - instr0 retains its last value.
- Throughput without stalls: 2 cycles per instruction (FETCH with immediate ack, then EXEC).
- Reset mid-fetch: mem_req drops immediately, asynchronously. Memory must discard the outstanding request.
- current_state is never driven to an undefined encoding; any illegal value returns to IDLE on the next edge.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - After a non-halt EXEC, go to STEP with pc already incremented.
  - STEP holds mem_req=0 until step=1, then -> FETCH.
  - A step pulse in any other state is ignored.
- Undefined:
  - STEP is unreachable and the step input is unused (tie off).
  - EXEC goes directly to FETCH.

Test Plan:
- Reset, then start=1 with memory acking in 1 cycle holding words 0x14001000, 0xD2041000, 0xFF000000 -> states 1,2,1,2,1,2,3; instr0 updates only on entering EXEC; pc sequence 0,1,2; halted=1 with pc=2.
- Memory ack delayed 5 cycles per fetch -> mem_req held high 6 cycles with mem_addr stable; EXEC still lasts 1 cycle; instr0 matches the acked data.
- TIMEOUT=8 with no ack -> fetch_err=1 and state=3 after the 8th wait cycle, mem_req=0; an ack arriving in exactly the 8th cycle instead completes the fetch with fetch_err=0.
- ADDR_W=4 with no halt word in memory -> pc wraps 15 -> 0 and the fetch at address 0 follows.
- reset_n pulled low while mem_req=1 -> mem_req=0 and state=0 with no clock edge; after release, the core stays in IDLE until start.
- SINGLE_STEP_EN defined -> after each EXEC the state is 4 and mem_req=0 indefinitely; a step pulse triggers the next fetch; a step pulse during FETCH has no effect.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 32-bit words over req/ack, owns the PC and core FSM, detects halt.
// Optional SINGLE_STEP_EN adds a STEP state that waits for a step pulse between instructions.
module instr_sequencer #(
    parameter int          ADDR_W  = 10,
    parameter int          TIMEOUT = 255,
    parameter logic [7:0]  HALT_OP = 8'hFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              step,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       instr0,
    output logic [3:0]        current_state,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              fetch_err
);

    localparam logic [3:0] STATE_IDLE  = 4'd0;
    localparam logic [3:0] STATE_FETCH = 4'd1;
    localparam logic [3:0] STATE_EXEC  = 4'd2;
    localparam logic [3:0] STATE_HALT  = 4'd3;
    localparam logic [3:0] STATE_STEP  = 4'd4;

    // The wait counter holds the number of FETCH cycles already spent without an ack.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

`ifdef SINGLE_STEP_EN
    localparam logic [3:0] STATE_AFTER_EXEC = STATE_STEP;
`else
    localparam logic [3:0] STATE_AFTER_EXEC = STATE_FETCH;
    logic w_unused_step;
    assign w_unused_step = step;
`endif

    logic [3:0]        r_state;
    logic [3:0]        w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr0;
    logic [15:0]       r_wait_cnt;
    logic              r_fetch_err;
    logic              w_timeout;
    logic              w_is_halt;
    logic              w_mem_req;
    logic              w_halted;

    assign w_timeout = (r_wait_cnt == WAIT_LAST);
    assign w_is_halt = (r_instr0[31:24] == HALT_OP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= STATE_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = STATE_IDLE;
        case (r_state)
            STATE_IDLE:  w_next_state = start ? STATE_FETCH : STATE_IDLE;
            STATE_FETCH: begin
                if (mem_ack) begin
                    w_next_state = STATE_EXEC;
                end else if (w_timeout) begin
                    w_next_state = STATE_HALT;
                end else begin
                    w_next_state = STATE_FETCH;
                end
            end
            STATE_EXEC:  w_next_state = w_is_halt ? STATE_HALT : STATE_AFTER_EXEC;
            STATE_HALT:  w_next_state = STATE_HALT;
`ifdef SINGLE_STEP_EN
            STATE_STEP:  w_next_state = step ? STATE_FETCH : STATE_STEP;
`endif
            default:     w_next_state = STATE_IDLE;
        endcase
    end

    always_comb begin
        w_mem_req = (r_state == STATE_FETCH);
        w_halted  = (r_state == STATE_HALT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc        <= '0;
            r_instr0    <= '0;
            r_wait_cnt  <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            case (r_state)
                STATE_IDLE: begin
                    r_wait_cnt <= '0;
                    if (start) begin
                        r_pc <= '0;
                    end
                end
                STATE_FETCH: begin
                    // An ack in the timeout cycle still wins.
                    if (mem_ack) begin
                        r_instr0   <= mem_rdata;
                        r_wait_cnt <= '0;
                    end else if (w_timeout) begin
                        r_fetch_err <= 1'b1;
                        r_wait_cnt  <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                STATE_EXEC: begin
                    if (!w_is_halt) begin
                        r_pc <= r_pc + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_req       = w_mem_req;
    assign mem_addr      = r_pc;
    assign instr0        = r_instr0;
    assign current_state = r_state;
    assign pc            = r_pc;
    assign halted        = w_halted;
    assign fetch_err     = r_fetch_err;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer (ADDR_W=4, TIMEOUT=8): directed vector table, multi-cycle corner
// sequences, and random programs checked against a program-level execution model.
module tb_instr_sequencer;

    localparam int AW      = 4;
    localparam int TMO     = 8;
    localparam int MEMSIZE = 16;
`ifdef SINGLE_STEP_EN
    localparam logic [3:0] S_AFTER = 4'd4;
`else
    localparam logic [3:0] S_AFTER = 4'd1;
`endif

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          step;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic [31:0]   instr0;
    logic [3:0]    current_state;
    logic [AW-1:0] pc;
    logic          halted;
    logic          fetch_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [MEMSIZE];
    int          dly_q[$];

    instr_sequencer #(.ADDR_W(AW), .TIMEOUT(TMO), .HALT_OP(8'hFF)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .step(step),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr0(instr0), .current_state(current_state), .pc(pc),
        .halted(halted), .fetch_err(fetch_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Memory responder: each new request takes the next delay from dly_q (0 if empty).
    int wcnt   = 0;
    int cur_d  = 0;
    bit active = 0;
    always @(negedge clk) begin
        if (!mem_req) begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            active    = 0;
            wcnt      = 0;
        end else begin
            if (!active) begin
                active = 1;
                wcnt   = 0;
                if (dly_q.size() > 0) cur_d = dly_q.pop_front();
                else cur_d = 0;
            end
            if (wcnt == cur_d) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                wcnt++;
            end
        end
    end

    // Protocol monitor: fetch address tracks pc; instr0 only changes on entering EXEC.
    logic [31:0] prev_instr;
    bit          prev_valid = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_valid = 0;
        end else begin
            if (mem_req) check("mem_addr_eq_pc", 64'(mem_addr), 64'(pc));
            if (prev_valid && instr0 !== prev_instr) check("instr0_change_state", 64'(current_state), 64'd2);
            prev_instr = instr0;
            prev_valid = 1;
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        step    = 1'b0;
        dly_q.delete();
        repeat (2) @(negedge clk);
        check("rst_state", 64'(current_state), 64'd0);
        check("rst_pc", 64'(pc), 64'd0);
        check("rst_instr0", 64'(instr0), 64'd0);
        check("rst_req", 64'(mem_req), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_err", 64'(fetch_err), 64'd0);
        reset_n = 1'b1;
    endtask

    // Random program run checked against a program-level model.
    task automatic run_prog(input int max_exec, input int halt_den, input int slow_den);
        logic [35:0] exp_q[$];
        int          dl[$];
        logic [31:0] w;
        logic [31:0] ins_m;
        int          pcm;
        int          ex;
        int          f;
        int          seen;
        bit          term;
        bit          err_m;
        bit          done;
        for (int i = 0; i < MEMSIZE; i++) begin
            w = $urandom;
            if (halt_den != 0 && $urandom_range(0, halt_den - 1) == 0) w[31:24] = 8'hFF;
            else if (w[31:24] == 8'hFF) w[31:24] = 8'h00;
            mem[i] = w;
        end
        for (int i = 0; i <= max_exec; i++) begin
            if (slow_den != 0 && $urandom_range(0, slow_den - 1) == 0) dl.push_back($urandom_range(6, 12));
            else dl.push_back($urandom_range(0, 3));
        end
        pcm = 0; ins_m = 0; ex = 0; f = 0; term = 0; err_m = 0;
        while (!term && ex < max_exec) begin
            if (dl[f] >= TMO) begin
                err_m = 1;
                term  = 1;
            end else begin
                ins_m = mem[pcm];
                exp_q.push_back({4'(pcm), ins_m});
                ex++;
                if (ins_m[31:24] == 8'hFF) term = 1;
                else pcm = (pcm + 1) % MEMSIZE;
            end
            f++;
        end
        do_reset();
        dly_q = dl;
        start = 1'b1;
        seen  = 0;
        done  = 0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
`ifdef SINGLE_STEP_EN
            step = (current_state == 4'd4);
`endif
            if (current_state == 4'd2) begin
                if (exp_q.size() == 0) check("exec_extra", 64'(seen), 64'(max_exec));
                else check("exec_trace", 64'({pc, instr0}), 64'(exp_q.pop_front()));
                seen++;
            end
            if (term) done = (halted === 1'b1);
            else done = (seen >= max_exec);
        end
        step = 1'b0;
        check("run_completed", 64'(done), 64'd1);
        check("trace_drained", 64'(exp_q.size()), 64'd0);
        if (term) begin
            check("end_halted", 64'(halted), 64'd1);
            check("end_err", 64'(fetch_err), 64'(err_m));
            check("end_pc", 64'(pc), 64'(pcm));
            check("end_instr0", 64'(instr0), 64'(ins_m));
        end
    endtask

    typedef struct {
        logic        start;
        logic        step;
        logic [3:0]  st;
        logic [3:0]  pcv;
        logic [31:0] ins;
        logic        req;
        logic        hlt;
    } vec_t;

    int n;

    initial begin
        vec_t tbl[9];
        reset_n   = 1'b0;
        start     = 1'b0;
        step      = 1'b0;
        tbl[0] = '{1'b1, 1'b0, 4'd1, 4'd0, 32'h00000000, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 4'd2, 4'd0, 32'h14001000, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 4'd1, 4'd1, 32'h14001000, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 4'd2, 4'd1, 32'hD2041000, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 4'd1, 4'd2, 32'hD2041000, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 4'd2, 4'd2, 32'hFF000000, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 4'd3, 4'd2, 32'hFF000000, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 4'd3, 4'd2, 32'hFF000000, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 4'd3, 4'd2, 32'hFF000000, 1'b0, 1'b1};
        for (int i = 0; i < MEMSIZE; i++) mem[i] = 32'h0;
        mem[0] = 32'h14001000;
        mem[1] = 32'hD2041000;
        mem[2] = 32'hFF000000;
        @(negedge clk);
        do_reset();

`ifndef SINGLE_STEP_EN
        // Immediate-ack program: 2 cycles per instruction, then halt at pc=2.
        for (int i = 0; i < 9; i++) begin
            start = tbl[i].start;
            step  = tbl[i].step;
            @(negedge clk);
            check($sformatf("vec%0d_state", i), 64'(current_state), 64'(tbl[i].st));
            check($sformatf("vec%0d_pc", i), 64'(pc), 64'(tbl[i].pcv));
            check($sformatf("vec%0d_instr0", i), 64'(instr0), 64'(tbl[i].ins));
            check($sformatf("vec%0d_req", i), 64'(mem_req), 64'(tbl[i].req));
            check($sformatf("vec%0d_halted", i), 64'(halted), 64'(tbl[i].hlt));
        end
        start = 1'b0;
        step  = 1'b0;
`else
        // Single-step: park in STEP with no request until a step pulse.
        do_reset();
        mem[0] = 32'h11111111;
        mem[1] = 32'h22222222;
        mem[2] = 32'hFF000000;
        dly_q = '{0, 3, 0};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("ss_exec0", 64'(current_state), 64'd2);
        @(negedge clk);
        check("ss_step_state", 64'(current_state), 64'd4);
        check("ss_step_pc", 64'(pc), 64'd1);
        repeat (5) begin
            @(negedge clk);
            check("ss_park_state", 64'(current_state), 64'd4);
            check("ss_park_req", 64'(mem_req), 64'd0);
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check("ss_fetch_after_step", 64'(current_state), 64'd1);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        check("ss_exec1", 64'(current_state), 64'd2);
        check("ss_exec1_instr", 64'(instr0), 64'h22222222);
        repeat (3) begin
            @(negedge clk);
            check("ss_fetch_pulse_ignored", 64'(current_state), 64'd4);
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
        check("ss_halt", 64'(halted), 64'd1);
        check("ss_halt_pc", 64'(pc), 64'd2);
`endif

        // Delayed ack: request held 6 cycles at a stable address.
        do_reset();
        mem[0] = 32'h12345678;
        mem[1] = 32'hFF000000;
        dly_q = '{5, 0};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && mem_req === 1'b1; c++) begin
            check("slow_addr_stable", 64'(mem_addr), 64'd0);
            n++;
            @(negedge clk);
        end
        check("slow_req_cycles", 64'(n), 64'd6);
        check("slow_exec_state", 64'(current_state), 64'd2);
        check("slow_exec_instr", 64'(instr0), 64'h12345678);
        @(negedge clk);
        check("slow_exec_one_cycle", 64'(current_state), 64'(S_AFTER));

        // Timeout with no ack: HALT with fetch_err after the 8th wait cycle.
        do_reset();
        dly_q = '{1000};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (TMO - 1) @(negedge clk);
        check("tmo_last_wait_state", 64'(current_state), 64'd1);
        check("tmo_last_wait_err", 64'(fetch_err), 64'd0);
        @(negedge clk);
        check("tmo_state", 64'(current_state), 64'd3);
        check("tmo_err", 64'(fetch_err), 64'd1);
        check("tmo_req", 64'(mem_req), 64'd0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check("tmo_start_ignored", 64'(current_state), 64'd3);

        // Ack in exactly the 8th cycle completes normally.
        do_reset();
        mem[0] = 32'hA5A50001;
        dly_q = '{TMO - 1};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (TMO) @(negedge clk);
        check("late_ack_state", 64'(current_state), 64'd2);
        check("late_ack_err", 64'(fetch_err), 64'd0);
        check("late_ack_instr", 64'(instr0), 64'hA5A50001);

        // Reset mid-fetch drops the request without a clock edge.
        do_reset();
        dly_q = '{1000};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("midrst_req_before", 64'(mem_req), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_req_async", 64'(mem_req), 64'd0);
        check("midrst_state_async", 64'(current_state), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_idle_hold", 64'(current_state), 64'd0);
            check("midrst_idle_req", 64'(mem_req), 64'd0);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("midrst_restart", 64'(current_state), 64'd1);

        // PC wrap 15 -> 0 with no halt word, then random programs.
        run_prog(20, 0, 0);
        for (int r = 0; r < 8; r++) run_prog(30, 8, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
